led_matrix_sched: RTL and testbench



---
 rtl/led_matrix_pkg.sv | 33 +++
 rtl/led_fb_2bank.sv | 66 ++++++
 rtl/led_matrix_sched.sv | 174 +++++++++++++++++
 tb/tb_led_matrix_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg
// Shared constants and types for the LED matrix scan scheduler.
//   - default matrix geometry and brightness depth
//   - write-address field widths and bit positions
//   - swap FSM state encoding
//   - slot_len(): cycles per scan slot (blanking + PWM)
package led_matrix_pkg;

    localparam int N_ANODE = 14;
    localparam int N_CATH  = 3;
    localparam int BW      = 4;
    localparam int DEAD    = 2;

    // wr_addr = {cath[1:0], anode[3:0]}
    localparam int ADDR_W    = 6;
    localparam int CATH_W    = 2;
    localparam int ANODE_W   = 4;
    localparam int CATH_MSB  = 5;
    localparam int CATH_LSB  = 4;
    localparam int ANODE_MSB = 3;
    localparam int ANODE_LSB = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } swap_state_t;

    // Blanking cycles followed by 2^bw-1 PWM cycles.
    function automatic int slot_len(input int dead, input int bw);
        return dead + (2 ** bw) - 1;
    endfunction

endpackage

// File: rtl/led_fb_2bank.sv
// led_fb_2bank
// Double-buffered brightness store: two banks of N_CATH x N_ANODE x BW.
// The bank selected by front_sel is read combinationally at the scan
// address; writes always land in the other (back) bank.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears all cells)
//   front_sel       bank currently being scanned
//   wr_en           write strobe (already qualified by the handshake)
//   wr_addr         {cath, anode}; out-of-range fields are silently dropped
//   wr_data         brightness level
//   rd_cath/anode   scan address
//   rd_level        brightness of the front bank at the scan address
module led_fb_2bank
    import led_matrix_pkg::*;
#(
    parameter int N_ANODE = led_matrix_pkg::N_ANODE,
    parameter int N_CATH  = led_matrix_pkg::N_CATH,
    parameter int BW      = led_matrix_pkg::BW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               front_sel,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [BW-1:0]      wr_data,
    input  logic [CATH_W-1:0]  rd_cath,
    input  logic [ANODE_W-1:0] rd_anode,
    output logic [BW-1:0]      rd_level
);

    logic [CATH_W-1:0]  wr_cath;
    logic [ANODE_W-1:0] wr_anode;
    logic               wr_in_range;
    logic [1:0][BW-1:0] bank_rd;

    assign wr_cath     = wr_addr[CATH_MSB:CATH_LSB];
    assign wr_anode    = wr_addr[ANODE_MSB:ANODE_LSB];
    // Addresses beyond the physical matrix are handshaken but never stored.
    assign wr_in_range = (32'(wr_cath) < N_CATH) && (32'(wr_anode) < N_ANODE);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [BW-1:0] cell_reg [N_CATH][N_ANODE];
            logic          bank_we;

            assign bank_we = wr_en && wr_in_range && (front_sel != 1'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int c = 0; c < N_CATH; c++) begin
                        for (int a = 0; a < N_ANODE; a++) begin
                            cell_reg[c][a] <= '0;
                        end
                    end
                end else if (bank_we) begin
                    cell_reg[wr_cath][wr_anode] <= wr_data;
                end
            end

            assign bank_rd[gi] = cell_reg[rd_cath][rd_anode];
        end
    endgenerate

    assign rd_level = bank_rd[front_sel];

endmodule

// File: rtl/led_matrix_sched.sv
// led_matrix_sched
// Scans a N_CATH x N_ANODE LED matrix one LED per slot. Each slot starts
// with DEAD blanking cycles, then a 2^BW-1 cycle PWM phase where the
// anode is held high and the cathode is high while p < level.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              scan enable; low blanks pins and parks the scan
//   wr_valid/wr_ready   back-bank write handshake (ready low while swap pending)
//   wr_addr, wr_data    {cath, anode} address and brightness
//   swap_req            pulse: swap banks at the next frame boundary
//   swap_ack            pulse: registered, marks the bank flip
//   frame_tick          pulse: registered, marks the last cycle of a frame
//   led_a, led_c        registered one-hot anode / cathode PWM pins
module led_matrix_sched
    import led_matrix_pkg::*;
#(
    parameter int N_ANODE = led_matrix_pkg::N_ANODE,
    parameter int N_CATH  = led_matrix_pkg::N_CATH,
    parameter int BW      = led_matrix_pkg::BW,
    parameter int DEAD    = led_matrix_pkg::DEAD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [BW-1:0]      wr_data,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               frame_tick,
    output logic [N_ANODE-1:0] led_a,
    output logic [N_CATH-1:0]  led_c
);

    localparam int SLOT_LEN = slot_len(DEAD, BW);
    localparam int CYC_W    = $clog2(SLOT_LEN);

    logic [CYC_W-1:0]   cyc_reg, cyc_next;
    logic [ANODE_W-1:0] anode_reg, anode_next;
    logic [CATH_W-1:0]  cath_reg, cath_next;
    logic               slot_last, anode_last, cath_last, frame_last;

    logic [CYC_W-1:0]   pwm_cnt;
    logic               in_pwm;
    logic [BW-1:0]      level;
    logic [N_ANODE-1:0] led_a_reg, led_a_next;
    logic [N_CATH-1:0]  led_c_reg, led_c_next;
    logic               frame_tick_reg, swap_ack_reg;

    swap_state_t        state_reg, state_next;
    logic               flip;
    logic               front_reg;
    logic               enable_prev_reg;
    logic               wr_en;

    // ---------------- scan counters ----------------
    assign slot_last  = (cyc_reg == CYC_W'(SLOT_LEN - 1));
    assign anode_last = (anode_reg == ANODE_W'(N_ANODE - 1));
    assign cath_last  = (cath_reg == CATH_W'(N_CATH - 1));
    assign frame_last = enable && slot_last && anode_last && cath_last;

    always_comb begin
        cyc_next   = cyc_reg;
        anode_next = anode_reg;
        cath_next  = cath_reg;
        if (!enable) begin
            // Parked at (c0, a0) cycle 0 so re-enable starts a clean frame.
            cyc_next   = '0;
            anode_next = '0;
            cath_next  = '0;
        end else if (slot_last) begin
            cyc_next = '0;
            if (anode_last) begin
                anode_next = '0;
                cath_next  = cath_last ? '0 : cath_reg + CATH_W'(1);
            end else begin
                anode_next = anode_reg + ANODE_W'(1);
            end
        end else begin
            cyc_next = cyc_reg + CYC_W'(1);
        end
    end

    // ---------------- pin generation ----------------
    assign in_pwm  = enable && (cyc_reg >= CYC_W'(DEAD));
    assign pwm_cnt = cyc_reg - CYC_W'(DEAD);

    always_comb begin
        led_a_next = '0;
        led_c_next = '0;
        if (in_pwm) begin
            led_a_next[anode_reg] = 1'b1;
            if (pwm_cnt < CYC_W'(level)) begin
                led_c_next[cath_reg] = 1'b1;
            end
        end
    end

    // ---------------- swap FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (swap_req) state_next = ST_PEND;
            // A swap_req arriving while pending (or on the flip) is absorbed.
            ST_PEND: if (flip)     state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // Flip at a frame boundary, or one cycle after the scan is parked by
    // enable low (enable_prev_reg low means no frame is in progress).
    always_comb begin
        wr_ready = (state_reg == ST_IDLE);
        flip     = (state_reg == ST_PEND) && (frame_last || !enable_prev_reg);
    end

    assign wr_en = wr_valid && wr_ready;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_reg         <= '0;
            anode_reg       <= '0;
            cath_reg        <= '0;
            led_a_reg       <= '0;
            led_c_reg       <= '0;
            frame_tick_reg  <= 1'b0;
            swap_ack_reg    <= 1'b0;
            front_reg       <= 1'b0;
            enable_prev_reg <= 1'b0;
        end else begin
            cyc_reg         <= cyc_next;
            anode_reg       <= anode_next;
            cath_reg        <= cath_next;
            led_a_reg       <= led_a_next;
            led_c_reg       <= led_c_next;
            frame_tick_reg  <= frame_last;
            swap_ack_reg    <= flip;
            front_reg       <= front_reg ^ flip;
            enable_prev_reg <= enable;
        end
    end

    led_fb_2bank #(
        .N_ANODE (N_ANODE),
        .N_CATH  (N_CATH),
        .BW      (BW)
    ) u_fb (
        .clk       (clk),
        .rst_n     (rst_n),
        .front_sel (front_reg),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_cath   (cath_reg),
        .rd_anode  (anode_reg),
        .rd_level  (level)
    );

    assign led_a      = led_a_reg;
    assign led_c      = led_c_reg;
    assign frame_tick = frame_tick_reg;
    assign swap_ack   = swap_ack_reg;

endmodule

// File: tb/tb_led_matrix_sched.sv
module tb_led_matrix_sched;

    localparam int NA    = 14;
    localparam int NC    = 3;
    localparam int FRAME = 714;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        swap_req;
    logic        swap_ack;
    logic        frame_tick;
    logic [13:0] led_a;
    logic [2:0]  led_c;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    // per-window statistics filled by observe()
    int a_hi[NA];
    int ca[NC][NA];
    int c_total, a_total, tick_cnt, ack_cnt, first_tick, bad;
    logic [13:0] a_at1, a_at2;

    always #5 clk = ~clk;

    led_matrix_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .frame_tick (frame_tick),
        .led_a      (led_a),
        .led_c      (led_c)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty observed=%0h", tag, obs);
        end else begin
            exp_v = sb_q.pop_front();
            $display("CHK %-16s observed=%0h expected=%0h", tag, obs, exp_v);
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [3:0] d, input logic with_swap);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        swap_req = with_swap;
        expect_val(1);
        chk("wr_ready_wr", 32'(wr_ready));
        step();
        wr_valid = 1'b0;
        swap_req = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_tick && n < 800);
        expect_val(1);
        chk(tag, 32'(frame_tick));
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!swap_ack && n < 800);
        expect_val(1);
        chk(tag, 32'(swap_ack));
    endtask

    task automatic observe(input int n);
        int zero_run;
        logic [13:0] prev_a;
        for (int i = 0; i < NA; i++) begin
            a_hi[i] = 0;
            for (int c = 0; c < NC; c++) ca[c][i] = 0;
        end
        c_total = 0; a_total = 0; tick_cnt = 0; ack_cnt = 0;
        first_tick = -1; bad = 0; a_at1 = '0; a_at2 = '0;
        zero_run = 0;
        prev_a = led_a;
        for (int k = 0; k < n; k++) begin
            step();
            if (k == 1) a_at1 = led_a;
            if (k == 2) a_at2 = led_a;
            if (frame_tick) begin
                tick_cnt++;
                if (first_tick < 0) first_tick = k;
            end
            if (swap_ack) ack_cnt++;
            if ($countones(led_a) > 1 || $countones(led_c) > 1 || (led_c != 0 && led_a == 0)) bad++;
            // cathode must have been low for DEAD cycles before a new anode lights
            if (led_a != 0 && led_a != prev_a && zero_run < 2) bad++;
            zero_run = (led_c == 0) ? zero_run + 1 : 0;
            if (led_a != 0) prev_a = led_a;
            for (int i = 0; i < NA; i++) begin
                if (led_a[i]) begin
                    a_hi[i]++;
                    a_total++;
                    for (int c = 0; c < NC; c++) if (led_c[c]) ca[c][i]++;
                end
            end
            for (int c = 0; c < NC; c++) if (led_c[c]) c_total++;
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; wr_valid = 1'b0; swap_req = 1'b0;
        wr_addr = '0; wr_data = '0;
        repeat (3) step();

        // reset values
        expect_val(0); chk("rst_led_a", 32'(led_a));
        expect_val(0); chk("rst_led_c", 32'(led_c));
        expect_val(1); chk("rst_wr_ready", 32'(wr_ready));
        expect_val(0); chk("rst_swap_ack", 32'(swap_ack));
        expect_val(0); chk("rst_frame_tick", 32'(frame_tick));

        // all-zero frame scan
        rst_n = 1'b1; enable = 1'b1;
        observe(FRAME);
        expect_val(0);   chk("f0_c_total", 32'(c_total));
        expect_val(630); chk("f0_a_total", 32'(a_total));
        expect_val(45);  chk("f0_a0_hi", 32'(a_hi[0]));
        expect_val(45);  chk("f0_a13_hi", 32'(a_hi[13]));
        expect_val(713); chk("f0_tick_pos", 32'(first_tick));
        expect_val(1);   chk("f0_tick_cnt", 32'(tick_cnt));
        expect_val(0);   chk("f0_bad", 32'(bad));
        expect_val(0);   chk("f0_a_blank", 32'(a_at1));
        expect_val(1);   chk("f0_a_first", 32'(a_at2));
        observe(FRAME);
        expect_val(713); chk("f1_tick_pos", 32'(first_tick));
        expect_val(1);   chk("f1_tick_cnt", 32'(tick_cnt));

        // load back bank (incl. out-of-range addresses), swap with a write in the same cycle
        do_write(6'h15, 4'd15, 1'b0);
        do_write(6'h20, 4'd7, 1'b0);
        do_write(6'h0F, 4'd15, 1'b0);
        do_write(6'h30, 4'd15, 1'b0);
        do_write(6'h0D, 4'd3, 1'b1);
        expect_val(0); chk("pend_wr_ready", 32'(wr_ready));
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        wr_valid = 1'b1; wr_addr = 6'h01; wr_data = 4'd15;
        expect_val(0); chk("pend_wr_block", 32'(wr_ready));
        step();
        wr_valid = 1'b0;
        wait_ack("swap1_ack");
        expect_val(1); chk("swap1_tick", 32'(frame_tick));
        expect_val(1); chk("swap1_wr_ready", 32'(wr_ready));
        observe(FRAME);
        expect_val(15); chk("s1_c1_a5", 32'(ca[1][5]));
        expect_val(7);  chk("s1_c2_a0", 32'(ca[2][0]));
        expect_val(3);  chk("s1_c0_a13", 32'(ca[0][13]));
        expect_val(25); chk("s1_c_total", 32'(c_total));
        expect_val(0);  chk("s1_ack_cnt", 32'(ack_cnt));
        expect_val(0);  chk("s1_bad", 32'(bad));
        observe(FRAME);
        expect_val(25); chk("s2_c_total", 32'(c_total));
        expect_val(0);  chk("s2_ack_cnt", 32'(ack_cnt));

        // enable drop mid-slot with a swap pending
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        repeat (7) step();
        expect_val(1); chk("en_led_a_on", 32'(led_a));
        expect_val(0); chk("en_pend_ready", 32'(wr_ready));
        enable = 1'b0;
        step();
        expect_val(0); chk("dis_led_a", 32'(led_a));
        expect_val(0); chk("dis_led_c", 32'(led_c));
        expect_val(0); chk("dis_ack_early", 32'(swap_ack));
        step();
        expect_val(1); chk("dis_swap_ack", 32'(swap_ack));
        expect_val(1); chk("dis_wr_ready", 32'(wr_ready));
        observe(30);
        expect_val(0); chk("dis_tick_cnt", 32'(tick_cnt));
        expect_val(0); chk("dis_a_total", 32'(a_total));
        expect_val(0); chk("dis_ack_cnt", 32'(ack_cnt));
        enable = 1'b1;
        observe(FRAME);
        expect_val(0);   chk("re_a_blank", 32'(a_at1));
        expect_val(1);   chk("re_a_first", 32'(a_at2));
        expect_val(713); chk("re_tick_pos", 32'(first_tick));
        expect_val(0);   chk("re_c_total", 32'(c_total));
        expect_val(630); chk("re_a_total", 32'(a_total));

        // asynchronous reset mid-frame with data and a pending swap
        do_write(6'h11, 4'd9, 1'b0);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        repeat (8) step();
        expect_val(1); chk("pre_rst_led_a", 32'(led_a));
        #3;
        rst_n = 1'b0;
        #1;
        expect_val(0); chk("arst_led_a", 32'(led_a));
        expect_val(0); chk("arst_led_c", 32'(led_c));
        expect_val(1); chk("arst_wr_ready", 32'(wr_ready));
        expect_val(0); chk("arst_swap_ack", 32'(swap_ack));
        step();
        rst_n = 1'b1;
        step();
        step();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        wait_ack("post_rst_ack");
        observe(FRAME);
        expect_val(0);   chk("post_rst_c_total", 32'(c_total));
        expect_val(630); chk("post_rst_a_total", 32'(a_total));

        if (sb_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_left observed=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
